// File: rtl/serial_link_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_pkg
// Shared definitions for the clk_32f serial byte link (transmitter, receiver
// and their benches).
//   WORD_W      : width of one link word in bits
//   COMMA_WORD  : 8'hBC comma used for sync preamble and idle fill
//   tx_state_t  : transmitter state (SYNC preamble, ACTIVE data)
// -----------------------------------------------------------------------------
package serial_link_pkg;

   localparam int WORD_W = 8;
   localparam logic [WORD_W-1:0] COMMA_WORD = 8'hBC;

   typedef enum logic [0:0] {
      SYNC   = 1'b0,
      ACTIVE = 1'b1
   } tx_state_t;

endpackage

// File: rtl/ser_shift8.sv
// -----------------------------------------------------------------------------
// ser_shift8
// 8-bit load/shift register with a free-running 0..7 bit counter. On the edge
// where the counter reads 7 (a boundary edge) the register loads word_i and the
// counter returns to 0; on every other edge the register shifts left, MSB first.
// Ports:
//   clk_i      : bit clock
//   rst_ni     : asynchronous active-low clear (register 0, counter 7)
//   word_i     : word to load at the next boundary edge
//   bit_o      : serial output, straight from the register MSB
//   boundary_o : high while the counter reads 7 (next edge loads word_i)
// -----------------------------------------------------------------------------
module ser_shift8
   import serial_link_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [WORD_W-1:0] word_i,
   output logic              bit_o,
   output logic              boundary_o
);

   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;

   assign boundary_o = (bit_cnt_q == 3'd7);
   assign bit_o      = shreg_q[WORD_W-1];

   // Load at a boundary, otherwise shift left with zero fill.
   always_comb begin
      shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (boundary_o) begin
         shreg_d   = word_i;
         bit_cnt_d = 3'd0;
      end
   end

   // Counter clears to 7 so the first edge after reset is a boundary.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shreg_q   <= '0;
         bit_cnt_q <= 3'd7;
      end else begin
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

endmodule

// File: rtl/serial_tx_comma.sv
// -----------------------------------------------------------------------------
// serial_tx_comma
// Transmit side of the clk_32f serial byte link. After reset it sends
// SYNC_WORDS 0xBC commas, then serialises user bytes MSB first, one bit per
// clock, filling idle word slots with 0xBC.
// Ports:
//   clk_32f        : bit clock, all flops on its rising edge
//   default_values : asynchronous active-low reset
//   data_in        : byte to transmit
//   valid_in       : data_in is valid (held by upstream until accepted)
//   ready_out      : word boundary; byte accepted at this edge when valid_in=1
//   data_out       : serial bit stream, MSB first (registered)
//   active         : high once the sync preamble is complete
// Parameters:
//   SYNC_WORDS     : commas sent after reset, 1..15
//   COMMA_PERIOD   : words between forced commas (PERIODIC_COMMA_EN only)
// Build option:
//   PERIODIC_COMMA_EN : when defined, every COMMA_PERIOD-th ACTIVE word slot is
//                       forced to a comma and refuses data.
// -----------------------------------------------------------------------------
module serial_tx_comma
   import serial_link_pkg::*;
#(
   parameter int SYNC_WORDS   = 4,
   parameter int COMMA_PERIOD = 16
) (
   input  logic              clk_32f,
   input  logic              default_values,
   input  logic [WORD_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic              data_out,
   output logic              active
);

   // Reject parameter values the counters cannot represent.
   if (SYNC_WORDS < 1 || SYNC_WORDS > 15) begin : g_bad_sync
      $error("serial_tx_comma: SYNC_WORDS must be 1..15");
   end
   if (COMMA_PERIOD < 2) begin : g_bad_period
      $error("serial_tx_comma: COMMA_PERIOD must be at least 2");
   end

   tx_state_t         state_q, state_d;
   logic [3:0]        sync_cnt_q, sync_cnt_d;
   logic              boundary;
   logic              force_comma;
   logic [WORD_W-1:0] next_word;

`ifdef PERIODIC_COMMA_EN
   localparam int WCW = (COMMA_PERIOD > 2) ? $clog2(COMMA_PERIOD) : 1;
   localparam logic [WCW-1:0] LAST_SLOT = WCW'(COMMA_PERIOD - 1);

   logic [WCW-1:0] word_cnt_q, word_cnt_d;

   // Word counter is held at 0 throughout SYNC, so it starts from 0 at the
   // first ACTIVE boundary and wraps after the forced-comma slot.
   always_comb begin
      word_cnt_d = word_cnt_q;
      if (state_q == SYNC) begin
         word_cnt_d = '0;
      end else if (boundary) begin
         word_cnt_d = (word_cnt_q == LAST_SLOT) ? '0 : word_cnt_q + WCW'(1);
      end
   end

   always_ff @(posedge clk_32f or negedge default_values) begin
      if (!default_values) begin
         word_cnt_q <= '0;
      end else begin
         word_cnt_q <= word_cnt_d;
      end
   end

   assign force_comma = (state_q == ACTIVE) && (word_cnt_q == LAST_SLOT);
`else
   assign force_comma = 1'b0;
`endif

   assign ready_out = (state_q == ACTIVE) && boundary && !force_comma;
   assign active    = (state_q == ACTIVE);

   // Anything other than an accepted byte is a comma (preamble, idle, forced).
   assign next_word = (ready_out && valid_in) ? data_in : COMMA_WORD;

   // Preamble counter: ACTIVE is entered on the boundary that loads the last
   // preamble comma, so active rises as that comma starts shifting out.
   always_comb begin
      state_d    = state_q;
      sync_cnt_d = sync_cnt_q;
      if (state_q == SYNC && boundary) begin
         sync_cnt_d = sync_cnt_q + 4'd1;
         if (sync_cnt_d == 4'(SYNC_WORDS)) begin
            state_d = ACTIVE;
         end
      end
   end

   always_ff @(posedge clk_32f or negedge default_values) begin
      if (!default_values) begin
         state_q    <= SYNC;
         sync_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         sync_cnt_q <= sync_cnt_d;
      end
   end

   ser_shift8 u_shift (
      .clk_i      (clk_32f),
      .rst_ni     (default_values),
      .word_i     (next_word),
      .bit_o      (data_out),
      .boundary_o (boundary)
   );

endmodule
